pc_sequencer: RTL and testbench

Parametrised program-counter unit for the ARMv8 datapath. It owns the PC register and computes the next fetch address for sequential flow, B, CBZ/CBNZ, B.cond (NZCV evaluation), BR, BL and RET. It adds stall, a one-cycle taken pulse for downstream flush, misaligned-target fault detection with halt, and a retired-instruction counter. It sits between decode/ALU and instruction memory.

---
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter unit: sequential/branch next-address selection, stall, misaligned-target halt, retire count.
// Optional return-address stack is built only when NEXTPC_RAS_EN is defined.
module pc_sequencer #(
    parameter int              WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             Stall,
    input  logic [2:0]       BranchMode,
    input  logic [3:0]       CondCode,
    input  logic [3:0]       Flags,
    input  logic             ALUZero,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] NextPC,
    output logic [WIDTH-1:0] LinkAddr,
    output logic             BranchTaken,
    output logic             Fault,
    output logic [31:0]      RetireCount
);

    localparam logic [2:0] MODE_SEQ   = 3'b000;
    localparam logic [2:0] MODE_B     = 3'b001;
    localparam logic [2:0] MODE_CBZ   = 3'b010;
    localparam logic [2:0] MODE_CBNZ  = 3'b011;
    localparam logic [2:0] MODE_BCOND = 3'b100;
    localparam logic [2:0] MODE_BR    = 3'b101;
    localparam logic [2:0] MODE_BL    = 3'b110;
    localparam logic [2:0] MODE_RET   = 3'b111;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_ras_depth_check
        $error("RAS_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q;
    logic             taken_q;
    logic             fault_q;
    logic [31:0]      retire_q;

    logic             flag_n, flag_z, flag_c, flag_v;
    logic             cond_pass;
    logic             taken;
    logic [WIDTH-1:0] offset_target;
    logic [WIDTH-1:0] seq_target;
    logic [WIDTH-1:0] ret_target;
    logic [WIDTH-1:0] target;
    logic             misaligned;
    logic             advance;
    logic             fault_now;
    logic [WIDTH-1:0] next_pc;

    assign {flag_n, flag_z, flag_c, flag_v} = Flags;
    assign offset_target = pc_q + (SignExtImm << 2);
    assign seq_target    = pc_q + WIDTH'(4);

    always_comb begin
        cond_pass = 1'b1;
        case (CondCode)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (BranchMode)
            MODE_SEQ:   taken = 1'b0;
            MODE_CBZ:   taken = ALUZero;
            MODE_CBNZ:  taken = !ALUZero;
            MODE_BCOND: taken = cond_pass;
            default:    taken = 1'b1;
        endcase
    end

`ifdef NEXTPC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_cnt;
    logic [PTR_W-1:0] ras_top_idx;
    logic             ras_empty;
    logic             ras_full;

    assign ras_top_idx = ras_ptr - PTR_W'(1);
    assign ras_empty   = (ras_cnt == '0);
    assign ras_full    = (ras_cnt == (PTR_W + 1)'(RAS_DEPTH));
    assign ret_target  = ras_empty ? RegTarget : ras_mem[ras_top_idx];

    // Circular stack: a push when full silently overwrites the oldest entry.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (advance) begin
            if (BranchMode == MODE_BL) begin
                ras_mem[ras_ptr] <= LinkAddr;
                ras_ptr          <= ras_ptr + PTR_W'(1);
                if (!ras_full) ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
            end else if (BranchMode == MODE_RET) begin
                if (ras_empty) begin
                    ras_ptr <= '0;
                end else begin
                    ras_ptr <= ras_top_idx;
                    ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
                end
            end
        end
    end
`else
    assign ret_target = RegTarget;
`endif

    assign target = (BranchMode == MODE_BR)  ? RegTarget  :
                    (BranchMode == MODE_RET) ? ret_target : offset_target;

    assign misaligned = taken && (target[1:0] != 2'b00);
    assign advance    = (state_q == RUN) && !Stall && !misaligned;
    assign fault_now  = (state_q == RUN) && !Stall && misaligned;

    always_comb begin
        state_d = state_q;
        next_pc = pc_q;
        if (advance) next_pc = taken ? target : seq_target;
        if (fault_now) state_d = HALT;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            taken_q  <= 1'b0;
            fault_q  <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            taken_q <= advance && taken;
            if (advance) begin
                pc_q     <= next_pc;
                retire_q <= retire_q + 32'd1;
            end
            if (fault_now) fault_q <= 1'b1;
        end
    end

    assign CurrentPC   = pc_q;
    assign NextPC      = next_pc;
    assign LinkAddr    = seq_target;
    assign BranchTaken = taken_q;
    assign Fault       = fault_q;
    assign RetireCount = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, B.cond sweep against a condition model, RAS/RET sequence.
module tb_pc_sequencer;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        Stall = 1'b0;
    logic [2:0]  BranchMode = 3'b000;
    logic [3:0]  CondCode = 4'h0;
    logic [3:0]  Flags = 4'h0;
    logic        ALUZero = 1'b0;
    logic [63:0] SignExtImm = '0;
    logic [63:0] RegTarget = '0;
    logic [63:0] CurrentPC, NextPC, LinkAddr;
    logic        BranchTaken, Fault;
    logic [31:0] RetireCount;

    pc_sequencer #(.WIDTH(64), .RESET_PC(RST_PC), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall), .BranchMode(BranchMode),
        .CondCode(CondCode), .Flags(Flags), .ALUZero(ALUZero),
        .SignExtImm(SignExtImm), .RegTarget(RegTarget),
        .CurrentPC(CurrentPC), .NextPC(NextPC), .LinkAddr(LinkAddr),
        .BranchTaken(BranchTaken), .Fault(Fault), .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [2:0]  mode;
        logic [3:0]  cc;
        logic [3:0]  flags;
        logic        az;
        logic [63:0] imm;
        logic [63:0] rt;
        logic [63:0] pc;
        logic        bt;
        logic        flt;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic        bt;
        logic        flt;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(input logic rst, input logic stall, input logic [2:0] mode,
                                input logic [3:0] cc, input logic [3:0] flags, input logic az,
                                input logic [63:0] imm, input logic [63:0] rt,
                                input logic [63:0] pc, input logic bt, input logic flt,
                                input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.mode = mode; v.cc = cc; v.flags = flags;
        v.az = az; v.imm = imm; v.rt = rt; v.pc = pc; v.bt = bt; v.flt = flt; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c & !z;
            4'h9: return !c | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge CLK);
        Reset_L = !v.rst; Stall = v.stall; BranchMode = v.mode; CondCode = v.cc;
        Flags = v.flags; ALUZero = v.az; SignExtImm = v.imm; RegTarget = v.rt;
        #1;
        if (!v.rst) check("next_pc", idx, NextPC, v.pc);
        e.pc = v.pc; e.bt = v.bt; e.flt = v.flt; e.cnt = v.cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty step=%0d got=0 want=1", idx);
        end else begin
            e = sb.pop_front();
            check("current_pc", idx, CurrentPC, e.pc);
            check("link_addr", idx, LinkAddr, e.pc + 64'd4);
            check("branch_taken", idx, {63'd0, BranchTaken}, {63'd0, e.bt});
            check("fault", idx, {63'd0, Fault}, {63'd0, e.flt});
            check("retire_count", idx, {32'd0, RetireCount}, {32'd0, e.cnt});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m_pc;
        logic [31:0] m_cnt;
        logic [63:0] r1, r2, r3, r4, r5, r6;
        logic        tk;
        int          idx;

        // rst stall mode cc flags az imm rt | pc bt flt cnt
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, RST_PC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 64'h1004, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 64'h1008, 0, 0, 2));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 64'h100C, 0, 0, 3));
        vecs.push_back(mk(0, 0, 3'b101, 0, 0, 0, 0, 64'h2000, 64'h2000, 1, 0, 4));
        vecs.push_back(mk(0, 0, 3'b010, 0, 0, 1, -64'sd2, 0, 64'h1FF8, 1, 0, 5));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 64'h1FFC, 0, 0, 6));
        vecs.push_back(mk(0, 0, 3'b101, 0, 0, 0, 0, 64'h2000, 64'h2000, 1, 0, 7));
        vecs.push_back(mk(0, 0, 3'b010, 0, 0, 0, -64'sd2, 0, 64'h2004, 0, 0, 8));
        vecs.push_back(mk(0, 0, 3'b100, 4'hC, 4'b1001, 0, 4, 0, 64'h2014, 1, 0, 9));
        vecs.push_back(mk(0, 0, 3'b100, 4'hC, 4'b1101, 0, 4, 0, 64'h2018, 0, 0, 10));
        vecs.push_back(mk(0, 0, 3'b011, 0, 0, 0, 8, 0, 64'h2038, 1, 0, 11));
        vecs.push_back(mk(0, 0, 3'b011, 0, 0, 1, 8, 0, 64'h203C, 0, 0, 12));
        vecs.push_back(mk(0, 1, 3'b001, 0, 0, 0, 100, 0, 64'h203C, 0, 0, 12));
        vecs.push_back(mk(0, 1, 3'b001, 0, 0, 0, 100, 0, 64'h203C, 0, 0, 12));
        vecs.push_back(mk(0, 0, 3'b001, 0, 0, 0, 100, 0, 64'h21CC, 1, 0, 13));
        vecs.push_back(mk(1, 1, 3'b001, 0, 0, 0, 100, 0, RST_PC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b101, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 64'h0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 3'b001, 0, 0, 0, '1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 3));
        vecs.push_back(mk(0, 0, 3'b101, 0, 0, 0, 0, 64'h3002, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 3));
        vecs.push_back(mk(0, 0, 3'b001, 0, 0, 0, 4, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 3));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 3));
        vecs.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, RST_PC, 0, 0, 0));

        // Nested BLs then RETs; stack keeps only the last four links.
`ifdef NEXTPC_RAS_EN
        r1 = 64'h1104; r2 = 64'h10C4; r3 = 64'h1084; r4 = 64'h1044; r5 = 64'hDEAD0; r6 = 64'hDEAD4;
`else
        r1 = 64'hDEAD0; r2 = 64'hDEAD0; r3 = 64'hDEAD0; r4 = 64'hDEAD0; r5 = 64'hDEAD0; r6 = 64'hDEAD0;
`endif
        vecs.push_back(mk(0, 0, 3'b110, 0, 0, 0, 16, 0, 64'h1040, 1, 0, 1));
        vecs.push_back(mk(0, 0, 3'b110, 0, 0, 0, 16, 0, 64'h1080, 1, 0, 2));
        vecs.push_back(mk(0, 0, 3'b110, 0, 0, 0, 16, 0, 64'h10C0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 3'b110, 0, 0, 0, 16, 0, 64'h1100, 1, 0, 4));
        vecs.push_back(mk(0, 0, 3'b110, 0, 0, 0, 16, 0, 64'h1140, 1, 0, 5));
        vecs.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r1, 1, 0, 6));
        vecs.push_back(mk(0, 1, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r1, 0, 0, 6));
        vecs.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r2, 1, 0, 7));
        vecs.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r3, 1, 0, 8));
        vecs.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r4, 1, 0, 9));
        vecs.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r5, 1, 0, 10));
        vecs.push_back(mk(0, 0, 3'b110, 0, 0, 0, 16, 0, 64'hDEB10, 1, 0, 11));
        vecs.push_back(mk(0, 0, 3'b111, 0, 0, 0, 0, 64'hDEAD0, r6, 1, 0, 12));

        idx = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], idx);
            idx++;
        end

        apply(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, RST_PC, 0, 0, 0), idx);
        idx++;
        m_pc  = RST_PC;
        m_cnt = 0;
        for (int cc = 0; cc < 16; cc++) begin
            for (int fl = 0; fl < 16; fl++) begin
                tk    = cond_ok(4'(cc), 4'(fl));
                m_pc  = tk ? m_pc + 64'd8 : m_pc + 64'd4;
                m_cnt = m_cnt + 1;
                apply(mk(0, 0, 3'b100, 4'(cc), 4'(fl), 0, 2, 0, m_pc, tk, 0, m_cnt), idx);
                idx++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
